// File: rtl/morgan_sweep_checker.sv
// Self-running De Morgan checker: sweeps every WIDTH-bit vector into an external DUT and
// checks its NAND/NOR outputs against OR-of-inverted / AND-of-inverted. Optional macro: MORGAN_STOP_ON_FAIL_EN.
module morgan_sweep_checker #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned HOLD  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] vec,
  input  logic             dut_nand,
  input  logic             dut_nor,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_count,
  output logic [WIDTH-1:0] first_fail_vec,
  output logic             first_fail_valid
);

  localparam int unsigned CW = WIDTH + 1;
  localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [WIDTH-1:0] VEC_MAX   = {WIDTH{1'b1}};
  localparam logic [CW-1:0]    ERR_MAX   = {1'b1, {WIDTH{1'b0}}};
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CW-1:0]    err_q, err_d;
  logic [WIDTH-1:0] ffv_q, ffv_d;
  logic             ffvalid_q, ffvalid_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sample_c;
  logic             mismatch_c;

  // DUT results compared against the other side of the law
  assign sample_c   = (hold_q == HOLD_LAST);
  assign mismatch_c = (dut_nand != (|(~vec_q))) | (dut_nor != (&(~vec_q)));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      vec_q     <= '0;
      hold_q    <= '0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
      pass_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      hold_q    <= hold_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
      pass_q    <= pass_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    hold_d    = hold_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    pass_d    = pass_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d   = ST_RUN;
          vec_d     = '0;
          hold_d    = '0;
          err_d     = '0;
          ffvalid_d = 1'b0;
          pass_d    = 1'b0;
        end
      end

      ST_RUN: begin
        if (abort) begin
          // Error record is kept for post-mortem inspection
          state_d = ST_IDLE;
          vec_d   = '0;
          hold_d  = '0;
          pass_d  = 1'b0;
        end else if (!sample_c) begin
          hold_d = hold_q + HW'(1);
        end else begin
          hold_d = '0;
          if (mismatch_c) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + CW'(1);
            end
            if (!ffvalid_q) begin
              ffv_d     = vec_q;
              ffvalid_d = 1'b1;
            end
          end
`ifdef MORGAN_STOP_ON_FAIL_EN
          if (mismatch_c || (vec_q == VEC_MAX)) begin
            state_d = ST_DONE;
          end else begin
            vec_d = vec_q + WIDTH'(1);
          end
`else
          if (vec_q == VEC_MAX) begin
            state_d = ST_DONE;
          end else begin
            vec_d = vec_q + WIDTH'(1);
          end
`endif
          if (state_d == ST_DONE) begin
            pass_d = (err_d == '0);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  assign vec              = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_morgan_sweep_checker.sv
// Directed bench for morgan_sweep_checker: a WIDTH=6/HOLD=1 instance and a WIDTH=4/HOLD=3 instance
// driven by behavioural De Morgan DUT models with injectable faults.
module tb_morgan_sweep_checker;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // WIDTH=6, HOLD=1 instance
  logic       start6, abort6, nand6, nor6;
  logic [5:0] vec6, ffv6;
  logic       busy6, done6, pass6, ffvalid6;
  logic [6:0] err6;
  int         fault_a, fault_b;

  // WIDTH=4, HOLD=3 instance
  logic       start4, abort4, nand4, nor4;
  logic [3:0] vec4, ffv4;
  logic       busy4, done4, pass4, ffvalid4;
  logic [4:0] err4;
  logic       fault4_all;

  morgan_sweep_checker #(.WIDTH(6), .HOLD(1)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .abort(abort6), .vec(vec6),
    .dut_nand(nand6), .dut_nor(nor6), .busy(busy6), .done(done6), .pass(pass6),
    .err_count(err6), .first_fail_vec(ffv6), .first_fail_valid(ffvalid6)
  );

  morgan_sweep_checker #(.WIDTH(4), .HOLD(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .vec(vec4),
    .dut_nand(nand4), .dut_nor(nor4), .busy(busy4), .done(done4), .pass(pass4),
    .err_count(err4), .first_fail_vec(ffv4), .first_fail_valid(ffvalid4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural DUTs: correct NAND/NOR unless a fault forces the NAND output low
  always_comb begin
    nand6 = ~&vec6;
    nor6  = ~|vec6;
    if (int'(vec6) == fault_a || int'(vec6) == fault_b) nand6 = 1'b0;
  end

  always_comb begin
    nand4 = fault4_all ? (&vec4) : ~&vec4;
    nor4  = ~|vec4;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (vec6 !== 6'd0 || busy6 !== 1'b0 || done6 !== 1'b0 || pass6 !== 1'b0) begin errors++; $display("FAIL reset6_ctrl vec=%0d busy=%b done=%b pass=%b required 0/0/0/0", vec6, busy6, done6, pass6); end
    checks++; if (err6 !== 7'd0 || ffv6 !== 6'd0 || ffvalid6 !== 1'b0) begin errors++; $display("FAIL reset6_err err=%0d ffv=%0d ffvalid=%b required 0/0/0", err6, ffv6, ffvalid6); end
    checks++; if (vec4 !== 4'd0 || busy4 !== 1'b0 || err4 !== 5'd0 || pass4 !== 1'b0) begin errors++; $display("FAIL reset4 vec=%0d busy=%b err=%0d pass=%b required 0", vec4, busy4, err4, pass4); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (busy6 !== 1'b0 || done6 !== 1'b0) begin errors++; $display("FAIL reset6_idle busy=%b done=%b required 0/0", busy6, done6); end
  endtask

  task automatic test_clean_sweep();
    start6 = 1'b1;
    step();
    start6 = 1'b0;
    for (int k = 0; k < 64; k++) begin
      checks++; if (vec6 !== 6'(k) || busy6 !== 1'b1 || done6 !== 1'b0) begin errors++; $display("FAIL clean_step k=%0d vec=%0d busy=%b done=%b required vec=%0d busy=1 done=0", k, vec6, busy6, done6, k); end
      step();
    end
    checks++; if (done6 !== 1'b1 || busy6 !== 1'b0) begin errors++; $display("FAIL clean_done done=%b busy=%b required 1/0", done6, busy6); end
    checks++; if (pass6 !== 1'b1 || err6 !== 7'd0 || ffvalid6 !== 1'b0) begin errors++; $display("FAIL clean_result pass=%b err=%0d ffvalid=%b required 1/0/0", pass6, err6, ffvalid6); end
    step();
    checks++; if (done6 !== 1'b0 || pass6 !== 1'b1) begin errors++; $display("FAIL clean_after done=%b pass=%b required 0/1", done6, pass6); end
  endtask

  task automatic test_fault_42();
    int cyc;
    fault_a = 42;
    start6 = 1'b1;
    step();
    start6 = 1'b0;
    cyc = 0;
    while (done6 !== 1'b1 && cyc < 200) begin step(); cyc++; end
`ifdef MORGAN_STOP_ON_FAIL_EN
    checks++; if (cyc !== 43 || vec6 !== 6'd42) begin errors++; $display("FAIL f42_timing cyc=%0d vec=%0d required 43/42", cyc, vec6); end
`else
    checks++; if (cyc !== 64 || vec6 !== 6'd63) begin errors++; $display("FAIL f42_timing cyc=%0d vec=%0d required 64/63", cyc, vec6); end
`endif
    checks++; if (err6 !== 7'd1 || ffv6 !== 6'd42 || ffvalid6 !== 1'b1 || pass6 !== 1'b0) begin errors++; $display("FAIL f42_result err=%0d ffv=%0d ffvalid=%b pass=%b required 1/42/1/0", err6, ffv6, ffvalid6, pass6); end
    fault_a = -1;
    step();
  endtask

  task automatic test_multi_fault();
    int cyc;
    fault_a = 5;
    fault_b = 9;
    start6 = 1'b1;
    step();
    start6 = 1'b0;
    cyc = 0;
    while (done6 !== 1'b1 && cyc < 200) begin step(); cyc++; end
`ifdef MORGAN_STOP_ON_FAIL_EN
    checks++; if (cyc !== 6 || vec6 !== 6'd5 || err6 !== 7'd1) begin errors++; $display("FAIL multi_result cyc=%0d vec=%0d err=%0d required 6/5/1", cyc, vec6, err6); end
`else
    checks++; if (cyc !== 64 || vec6 !== 6'd63 || err6 !== 7'd2) begin errors++; $display("FAIL multi_result cyc=%0d vec=%0d err=%0d required 64/63/2", cyc, vec6, err6); end
`endif
    checks++; if (ffv6 !== 6'd5 || ffvalid6 !== 1'b1 || pass6 !== 1'b0) begin errors++; $display("FAIL multi_first ffv=%0d ffvalid=%b pass=%b required 5/1/0", ffv6, ffvalid6, pass6); end
    fault_a = -1;
    fault_b = -1;
    step();
    step();
    checks++; if (pass6 !== 1'b0 || err6 === 7'd0 || ffv6 !== 6'd5) begin errors++; $display("FAIL multi_hold pass=%b err=%0d ffv=%0d required 0/nonzero/5", pass6, err6, ffv6); end
  endtask

  task automatic test_hold3();
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int k = 0; k < 48; k++) begin
      checks++; if (vec4 !== 4'(k / 3) || busy4 !== 1'b1 || done4 !== 1'b0) begin errors++; $display("FAIL hold3_step k=%0d vec=%0d busy=%b done=%b required vec=%0d busy=1 done=0", k, vec4, busy4, done4, k / 3); end
      start4 = (k == 10);
      step();
    end
    start4 = 1'b0;
    checks++; if (done4 !== 1'b1 || pass4 !== 1'b1 || err4 !== 5'd0 || vec4 !== 4'd15) begin errors++; $display("FAIL hold3_done done=%b pass=%b err=%0d vec=%0d required 1/1/0/15", done4, pass4, err4, vec4); end
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin errors++; $display("FAIL hold3_start_in_done busy=%b done=%b required 0/0", busy4, done4); end
  endtask

  task automatic test_all_fail4();
    int cyc;
    fault4_all = 1'b1;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    cyc = 0;
    while (done4 !== 1'b1 && cyc < 200) begin step(); cyc++; end
`ifdef MORGAN_STOP_ON_FAIL_EN
    checks++; if (cyc !== 3 || err4 !== 5'd1 || vec4 !== 4'd0) begin errors++; $display("FAIL allfail_result cyc=%0d err=%0d vec=%0d required 3/1/0", cyc, err4, vec4); end
`else
    checks++; if (cyc !== 48 || err4 !== 5'd16 || vec4 !== 4'd15) begin errors++; $display("FAIL allfail_result cyc=%0d err=%0d vec=%0d required 48/16/15", cyc, err4, vec4); end
`endif
    checks++; if (ffv4 !== 4'd0 || ffvalid4 !== 1'b1 || pass4 !== 1'b0) begin errors++; $display("FAIL allfail_first ffv=%0d ffvalid=%b pass=%b required 0/1/0", ffv4, ffvalid4, pass4); end
    fault4_all = 1'b0;
    step();
  endtask

  task automatic test_abort();
    int cyc;
    int done_seen;
    start6 = 1'b1;
    step();
    start6 = 1'b0;
    for (int k = 0; k < 20; k++) step();
    checks++; if (vec6 !== 6'd20 || busy6 !== 1'b1) begin errors++; $display("FAIL abort_pre vec=%0d busy=%b required 20/1", vec6, busy6); end
    abort6 = 1'b1;
    step();
    abort6 = 1'b0;
    checks++; if (busy6 !== 1'b0 || vec6 !== 6'd0 || done6 !== 1'b0 || pass6 !== 1'b0) begin errors++; $display("FAIL abort_post busy=%b vec=%0d done=%b pass=%b required 0/0/0/0", busy6, vec6, done6, pass6); end
    done_seen = 0;
    for (int k = 0; k < 5; k++) begin step(); if (done6 === 1'b1) done_seen++; end
    checks++; if (done_seen !== 0 || busy6 !== 1'b0) begin errors++; $display("FAIL abort_no_done done_pulses=%0d busy=%b required 0/0", done_seen, busy6); end
    start6 = 1'b1;
    step();
    start6 = 1'b0;
    cyc = 0;
    while (done6 !== 1'b1 && cyc < 200) begin step(); cyc++; end
    checks++; if (cyc !== 64 || pass6 !== 1'b1 || err6 !== 7'd0) begin errors++; $display("FAIL abort_rerun cyc=%0d pass=%b err=%0d required 64/1/0", cyc, pass6, err6); end
    step();
  endtask

  task automatic test_reset_mid();
    int cyc;
    fault_a = 3;
    start6 = 1'b1;
    step();
    start6 = 1'b0;
    for (int k = 0; k < 10; k++) step();
    checks++; if (err6 !== 7'd1 || ffvalid6 !== 1'b1) begin errors++; $display("FAIL rstmid_pre err=%0d ffvalid=%b required 1/1", err6, ffvalid6); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (vec6 !== 6'd0 || busy6 !== 1'b0 || done6 !== 1'b0 || pass6 !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl vec=%0d busy=%b done=%b pass=%b required 0/0/0/0", vec6, busy6, done6, pass6); end
    checks++; if (err6 !== 7'd0 || ffv6 !== 6'd0 || ffvalid6 !== 1'b0) begin errors++; $display("FAIL rstmid_err err=%0d ffv=%0d ffvalid=%b required 0/0/0", err6, ffv6, ffvalid6); end
    fault_a = -1;
    step();
    rst_n = 1'b1;
    step();
    start6 = 1'b1;
    step();
    start6 = 1'b0;
    cyc = 0;
    while (done6 !== 1'b1 && cyc < 200) begin step(); cyc++; end
    checks++; if (cyc !== 64 || pass6 !== 1'b1 || err6 !== 7'd0 || ffvalid6 !== 1'b0) begin errors++; $display("FAIL rstmid_rerun cyc=%0d pass=%b err=%0d ffvalid=%b required 64/1/0/0", cyc, pass6, err6, ffvalid6); end
    step();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    start6     = 1'b0;
    abort6     = 1'b0;
    start4     = 1'b0;
    abort4     = 1'b0;
    fault_a    = -1;
    fault_b    = -1;
    fault4_all = 1'b0;
    test_reset();
    test_clean_sweep();
    test_fault_42();
    test_multi_fault();
    test_hold3();
    test_all_fail4();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
